// File: rtl/cdb_arbiter_pkg.sv
// Shared writeback packet type and CDB sizing used by the CDB arbiter and its selector.
package cdb_arbiter_pkg;

  localparam int unsigned PIPE_WIDTH = 2;
  localparam int unsigned TAG_WIDTH  = 6;
  localparam int unsigned DATA_WIDTH = 32;

  typedef struct packed {
    logic                  is_valid;
    logic [TAG_WIDTH-1:0]  dest_tag;
    logic [DATA_WIDTH-1:0] result;
  } writeback_packet_t;

  // Index width that stays at least one bit for single-entry arrays.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_rr_select.sv
// Combinational round-robin multi-grant selector: picks up to NUM_CDB requesters,
// scanning upward from rr_ptr modulo NUM_FU; port k receives the k-th pick.
module cdb_rr_select
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_FU  = 4,
  parameter int unsigned NUM_CDB = PIPE_WIDTH,
  localparam int unsigned IDX_W  = idx_width(NUM_FU)
) (
  input  logic [NUM_FU-1:0]  req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   grant_idx [NUM_CDB],
  output logic [NUM_CDB-1:0] grant_vld
);

  localparam int unsigned CNT_W = idx_width(NUM_CDB);

  always_comb begin
    int unsigned cnt;
    int unsigned idx;
    cnt       = 0;
    idx       = 0;
    grant_vld = '0;
    for (int unsigned k = 0; k < NUM_CDB; k++) begin
      grant_idx[k] = '0;
    end
    for (int unsigned off = 0; off < NUM_FU; off++) begin
      idx = (32'(rr_ptr) + off) % NUM_FU;
      if (req[IDX_W'(idx)] && (cnt < NUM_CDB)) begin
        grant_idx[CNT_W'(cnt)] = IDX_W'(idx);
        grant_vld[CNT_W'(cnt)] = 1'b1;
        cnt = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per FU, round-robin multi-grant onto NUM_CDB
// registered broadcast ports. Define CDB_BYPASS_EN to let empty-slot arrivals compete same cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_FU  = 4,
  parameter int unsigned NUM_CDB = PIPE_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  writeback_packet_t fu_wb_pkt [NUM_FU],
  output logic [NUM_FU-1:0] fu_wb_rdy,
  output writeback_packet_t cdb_ports [NUM_CDB]
);

  localparam int unsigned      IDX_W    = idx_width(NUM_FU);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FU - 1);

  writeback_packet_t  slot_q [NUM_FU];
  writeback_packet_t  slot_d [NUM_FU];
  logic [NUM_FU-1:0]  occ_q, occ_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  writeback_packet_t  cdb_d [NUM_CDB];

  logic [NUM_FU-1:0]  req, granted, xfer, bypassed;
  writeback_packet_t  cand [NUM_FU];
  logic [IDX_W-1:0]   grant_idx [NUM_CDB];
  logic [NUM_CDB-1:0] grant_vld;

  // An occupied slot always wins over a same-FU arrival; arrivals only compete for empty slots.
  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
`ifdef CDB_BYPASS_EN
      req[i]  = occ_q[i] | fu_wb_pkt[i].is_valid;
      cand[i] = occ_q[i] ? slot_q[i] : fu_wb_pkt[i];
`else
      req[i]  = occ_q[i];
      cand[i] = slot_q[i];
`endif
    end
  end

  cdb_rr_select #(
    .NUM_FU  (NUM_FU),
    .NUM_CDB (NUM_CDB)
  ) u_select (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  always_comb begin
    granted = '0;
    for (int unsigned k = 0; k < NUM_CDB; k++) begin
      if (grant_vld[k]) begin
        granted[grant_idx[k]] = 1'b1;
      end
    end
  end

  assign fu_wb_rdy = ~occ_q | granted | {NUM_FU{flush}};
  // A granted empty slot means the arrival went straight to the bus and must not be stored.
  assign bypassed  = granted & ~occ_q;

  always_comb begin
    xfer = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      xfer[i] = fu_wb_pkt[i].is_valid & fu_wb_rdy[i];
    end
  end

  always_comb begin
    slot_d = slot_q;
    occ_d  = occ_q;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (flush) begin
        occ_d[i] = 1'b0;
      end else if (xfer[i] && !bypassed[i]) begin
        slot_d[i] = fu_wb_pkt[i];
        occ_d[i]  = 1'b1;
      end else if (granted[i]) begin
        occ_d[i] = 1'b0;
      end
    end
  end

  // Later ports hold later picks in scan order, so the last write leaves the final grant.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    for (int unsigned k = 0; k < NUM_CDB; k++) begin
      cdb_d[k] = '0;
      if (!flush && grant_vld[k]) begin
        cdb_d[k] = cand[grant_idx[k]];
        rr_ptr_d = (grant_idx[k] == LAST_IDX) ? '0 : grant_idx[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q    <= '0;
      rr_ptr_q <= '0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        slot_q[i] <= '0;
      end
      for (int unsigned k = 0; k < NUM_CDB; k++) begin
        cdb_ports[k] <= '0;
      end
    end else begin
      occ_q     <= occ_d;
      rr_ptr_q  <= rr_ptr_d;
      slot_q    <= slot_d;
      cdb_ports <= cdb_d;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic against a queue-based model.
// Define CDB_BYPASS_EN for both bench and RTL to exercise the same-cycle bypass build.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NF = 4;
  localparam int NC = PIPE_WIDTH;

  logic              clk   = 1'b0;
  logic              rst   = 1'b1;
  logic              flush = 1'b0;
  writeback_packet_t fu_wb_pkt [NF];
  logic [NF-1:0]     fu_wb_rdy;
  writeback_packet_t cdb_ports [NC];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  bit                m_occ  [NF];
  writeback_packet_t m_slot [NF];
  writeback_packet_t m_cdb  [NC];
  int                m_rr;
  logic [NF-1:0]     m_rdy;
  logic [NF-1:0]     obs_rdy;
  int                m_gnt [$];

  cdb_arbiter #(
    .NUM_FU  (NF),
    .NUM_CDB (NC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .fu_wb_pkt (fu_wb_pkt),
    .fu_wb_rdy (fu_wb_rdy),
    .cdb_ports (cdb_ports)
  );

  always #5 clk = ~clk;

  function automatic writeback_packet_t mk(input logic [TAG_WIDTH-1:0] tag,
                                           input logic [DATA_WIDTH-1:0] res);
    mk = {1'b1, tag, res};
  endfunction

  task automatic idle_all();
    for (int i = 0; i < NF; i++) fu_wb_pkt[i] = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      m_occ[i]  = 1'b0;
      m_slot[i] = '0;
    end
    for (int k = 0; k < NC; k++) m_cdb[k] = '0;
    m_rr = 0;
  endtask

  // One clock: sample ready mid-cycle, advance the model at the edge, return 1 time unit later.
  task automatic tick();
    bit is_g [NF];
    bit elig;
    int j;
    @(negedge clk);
    obs_rdy = fu_wb_rdy;
    m_gnt.delete();
    for (int i = 0; i < NF; i++) is_g[i] = 1'b0;
    for (int off = 0; off < NF; off++) begin
      j    = (m_rr + off) % NF;
      elig = m_occ[j];
`ifdef CDB_BYPASS_EN
      elig = elig | fu_wb_pkt[j].is_valid;
`endif
      if (elig && m_gnt.size() < NC) begin
        m_gnt.push_back(j);
        is_g[j] = 1'b1;
      end
    end
    for (int i = 0; i < NF; i++) m_rdy[i] = !m_occ[i] || is_g[i] || flush;
    @(posedge clk);
    if (flush) begin
      for (int i = 0; i < NF; i++) m_occ[i] = 1'b0;
      for (int k = 0; k < NC; k++) m_cdb[k] = '0;
    end else begin
      for (int k = 0; k < NC; k++) begin
        if (k < m_gnt.size())
          m_cdb[k] = m_occ[m_gnt[k]] ? m_slot[m_gnt[k]] : fu_wb_pkt[m_gnt[k]];
        else
          m_cdb[k] = '0;
      end
      for (int i = 0; i < NF; i++) begin
        if (fu_wb_pkt[i].is_valid && m_rdy[i] && !(is_g[i] && !m_occ[i])) begin
          m_slot[i] = fu_wb_pkt[i];
          m_occ[i]  = 1'b1;
        end else if (is_g[i]) begin
          m_occ[i] = 1'b0;
        end
      end
      if (m_gnt.size() > 0) m_rr = (m_gnt[m_gnt.size()-1] + 1) % NF;
    end
    #1;
  endtask

  task automatic pulse_reset();
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    idle_all();
    flush = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    for (int k = 0; k < NC; k++) begin
      n_cmp++;
      if (cdb_ports[k] !== '0) begin
        n_fail++;
        $display("FAIL reset_cdb[%0d]: got %h want 0", k, cdb_ports[k]);
      end
    end
    n_cmp++;
    if (fu_wb_rdy !== '1) begin
      n_fail++;
      $display("FAIL reset_rdy: got %b want 1111", fu_wb_rdy);
    end
    n_cmp++;
    if (dut.rr_ptr_q !== '0) begin
      n_fail++;
      $display("FAIL reset_rr: got %0d want 0", dut.rr_ptr_q);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    tick();
    n_cmp++;
    if (obs_rdy !== '1 || cdb_ports[0].is_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: rdy %b valid %b want 1111/0", obs_rdy, cdb_ports[0].is_valid);
    end
  endtask

`ifndef CDB_BYPASS_EN
  task automatic test_single_latency();
    writeback_packet_t p;
    p = mk(6'd5, 32'hDEAD);
    fu_wb_pkt[0] = p;
    tick();
    idle_all();
    n_cmp++;
    if (cdb_ports[0].is_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early: cycle1 valid %b want 0", cdb_ports[0].is_valid);
    end
    tick();
    n_cmp++;
    if (cdb_ports[0] !== p) begin
      n_fail++;
      $display("FAIL single_cycle2: got %h want %h", cdb_ports[0], p);
    end
    n_cmp++;
    if (cdb_ports[1].is_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_port1: valid %b want 0", cdb_ports[1].is_valid);
    end
    tick();
    n_cmp++;
    if (cdb_ports[0].is_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_cycle3: valid %b want 0", cdb_ports[0].is_valid);
    end
  endtask

  task automatic test_all_fus();
    writeback_packet_t p [NF];
    pulse_reset();
    for (int i = 0; i < NF; i++) begin
      p[i]         = mk(TAG_WIDTH'(i + 1), $urandom());
      fu_wb_pkt[i] = p[i];
    end
    tick();
    idle_all();
    tick();
    n_cmp++;
    if (obs_rdy !== 4'b0011) begin
      n_fail++;
      $display("FAIL all_rdy_cycle1: got %b want 0011", obs_rdy);
    end
    n_cmp++;
    if (cdb_ports[0] !== p[0] || cdb_ports[1] !== p[1]) begin
      n_fail++;
      $display("FAIL all_cycle2: got %h %h want %h %h", cdb_ports[0], cdb_ports[1], p[0], p[1]);
    end
    n_cmp++;
    if (dut.rr_ptr_q !== 2'd2) begin
      n_fail++;
      $display("FAIL all_rr_cycle2: got %0d want 2", dut.rr_ptr_q);
    end
    tick();
    n_cmp++;
    if (cdb_ports[0] !== p[2] || cdb_ports[1] !== p[3]) begin
      n_fail++;
      $display("FAIL all_cycle3: got %h %h want %h %h", cdb_ports[0], cdb_ports[1], p[2], p[3]);
    end
    n_cmp++;
    if (dut.rr_ptr_q !== 2'd0) begin
      n_fail++;
      $display("FAIL all_rr_cycle3: got %0d want 0", dut.rr_ptr_q);
    end
  endtask

  task automatic test_wrap();
    writeback_packet_t pa, p1, p3;
    pa = mk(6'd7, $urandom());
    fu_wb_pkt[2] = pa;
    tick();
    idle_all();
    tick();
    n_cmp++;
    if (dut.rr_ptr_q !== 2'd3) begin
      n_fail++;
      $display("FAIL wrap_setup_rr: got %0d want 3", dut.rr_ptr_q);
    end
    p3 = mk(6'd8, $urandom());
    fu_wb_pkt[3] = p3;
    tick();
    p1 = mk(6'd9, $urandom());
    fu_wb_pkt[1] = p1;
    tick();
    fu_wb_pkt[1] = '0;
    n_cmp++;
    if (dut.rr_ptr_q !== 2'd0 || cdb_ports[0] !== p3) begin
      n_fail++;
      $display("FAIL wrap_3to0: rr %0d cdb0 %h want 0 / %h", dut.rr_ptr_q, cdb_ports[0], p3);
    end
    n_cmp++;
    if (obs_rdy[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_rdy3: got %b want 1", obs_rdy[3]);
    end
    tick();
    n_cmp++;
    if (cdb_ports[0] !== p1 || cdb_ports[1] !== p3) begin
      n_fail++;
      $display("FAIL wrap_both: got %h %h want %h %h", cdb_ports[0], cdb_ports[1], p1, p3);
    end
    fu_wb_pkt[3] = '0;
    tick();
    tick();
  endtask

  task automatic test_flush();
    fu_wb_pkt[0] = mk(6'd1, $urandom());
    tick();
    idle_all();
    tick();
    for (int i = 0; i < 3; i++) fu_wb_pkt[i] = mk(TAG_WIDTH'(i + 20), $urandom());
    tick();
    idle_all();
    fu_wb_pkt[3] = mk(6'd33, $urandom());
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle_all();
    n_cmp++;
    if (obs_rdy !== '1) begin
      n_fail++;
      $display("FAIL flush_rdy: got %b want 1111", obs_rdy);
    end
    for (int c = 2; c <= 3; c++) begin
      for (int k = 0; k < NC; k++) begin
        n_cmp++;
        if (cdb_ports[k].is_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL flush_cdb[%0d] cycle%0d: valid %b want 0", k, c, cdb_ports[k].is_valid);
        end
      end
      n_cmp++;
      if (dut.rr_ptr_q !== 2'd1) begin
        n_fail++;
        $display("FAIL flush_rr cycle%0d: got %0d want 1", c, dut.rr_ptr_q);
      end
      tick();
    end
    n_cmp++;
    if (obs_rdy !== '1) begin
      n_fail++;
      $display("FAIL flush_slots_cleared: rdy %b want 1111", obs_rdy);
    end
  endtask
`else
  task automatic test_bypass();
    writeback_packet_t p;
    pulse_reset();
    p = mk(6'd9, $urandom());
    fu_wb_pkt[2] = p;
    tick();
    idle_all();
    n_cmp++;
    if (cdb_ports[0] !== p) begin
      n_fail++;
      $display("FAIL bypass_cycle1: got %h want %h", cdb_ports[0], p);
    end
    n_cmp++;
    if (dut.rr_ptr_q !== 2'd3) begin
      n_fail++;
      $display("FAIL bypass_rr: got %0d want 3", dut.rr_ptr_q);
    end
    tick();
    n_cmp++;
    if (cdb_ports[0].is_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_no_repeat: valid %b want 0", cdb_ports[0].is_valid);
    end
  endtask
`endif

  task automatic test_reset_midburst();
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 3; i++) fu_wb_pkt[i] = mk(TAG_WIDTH'($urandom()), $urandom());
      tick();
      n_cmp++;
      if (int'(dut.rr_ptr_q) !== m_rr) begin
        n_fail++;
        $display("FAIL burst_rr c%0d: got %0d want %0d", c, dut.rr_ptr_q, m_rr);
      end
    end
    #2;
    rst = 1'b0;
    #1;
    for (int k = 0; k < NC; k++) begin
      n_cmp++;
      if (cdb_ports[k] !== '0) begin
        n_fail++;
        $display("FAIL midrst_cdb[%0d]: got %h want 0", k, cdb_ports[k]);
      end
    end
    n_cmp++;
    if (fu_wb_rdy !== 4'hF || dut.rr_ptr_q !== '0) begin
      n_fail++;
      $display("FAIL midrst_state: rdy %b rr %0d want 1111 / 0", fu_wb_rdy, dut.rr_ptr_q);
    end
    idle_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < 2; c++) begin
      tick();
      for (int k = 0; k < NC; k++) begin
        n_cmp++;
        if (cdb_ports[k].is_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL midrst_after[%0d] c%0d: valid %b want 0", k, c, cdb_ports[k].is_valid);
        end
      end
    end
  endtask

  task automatic test_random(input int n);
    for (int c = 0; c < n; c++) begin
      flush = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NF; i++) begin
        fu_wb_pkt[i] = {1'b0, TAG_WIDTH'($urandom()), DATA_WIDTH'($urandom())};
        if ($urandom_range(0, 99) < 60) fu_wb_pkt[i].is_valid = 1'b1;
      end
      tick();
      n_cmp++;
      if (obs_rdy !== m_rdy) begin
        n_fail++;
        $display("FAIL rand_rdy c%0d: got %b want %b", c, obs_rdy, m_rdy);
      end
      for (int k = 0; k < NC; k++) begin
        n_cmp++;
        if (cdb_ports[k] !== m_cdb[k]) begin
          n_fail++;
          $display("FAIL rand_cdb[%0d] c%0d: got %h want %h", k, c, cdb_ports[k], m_cdb[k]);
        end
      end
      n_cmp++;
      if (int'(dut.rr_ptr_q) !== m_rr) begin
        n_fail++;
        $display("FAIL rand_rr c%0d: got %0d want %0d", c, dut.rr_ptr_q, m_rr);
      end
    end
    flush = 1'b0;
    idle_all();
  endtask

  initial begin
    idle_all();
    model_reset();
    test_reset();
`ifndef CDB_BYPASS_EN
    test_single_latency();
    test_all_fus();
    test_wrap();
    test_flush();
`else
    test_bypass();
`endif
    test_reset_midburst();
    test_random(400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_FU, default 4, number of functional-unit writeback sources.
REQ-002 SHALL have parameter NUM_CDB, default PIPE_WIDTH, number of CDB broadcast ports.
REQ-003 SHALL have clk  input  1  the single clock; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have flush  input  1  synchronous pipeline flush, active-high.
REQ-006 SHALL have fu_wb_pkt  input  writeback_packet_t[NUM_FU]  FU results; is_valid marks a request.
REQ-007 SHALL have fu_wb_rdy  output  [NUM_FU]  per-FU accept; transfer when is_valid and fu_wb_rdy are both high.
REQ-008 SHALL have cdb_ports  output  writeback_packet_t[NUM_CDB]  registered broadcast to reservation stations and ROB.

Function
REQ-009 SHALL hold one holding slot per FU (packet plus occupied bit).
REQ-010 SHALL drive fu_wb_rdy[i] = slot i empty, or slot i granted this cycle, or flush high.
REQ-011 SHALL load slot i on transfer; a packet with is_valid=0 SHALL never occupy a slot.
REQ-012 SHALL grant up to NUM_CDB occupied slots per cycle, scanning round-robin from rr_ptr upward modulo NUM_FU.
REQ-013 SHALL assign the k-th granted slot in scan order to cdb_ports[k]; ungranted ports SHALL carry is_valid=0 next cycle.
REQ-014 SHALL register granted packets into cdb_ports at the clock edge; a slot granted and reloaded in the same cycle SHALL hold the new packet.
REQ-015 SHALL set rr_ptr to (last granted index + 1) mod NUM_FU after any grant; no grant SHALL leave rr_ptr unchanged.
REQ-016 SHALL give latency of 2 cycles: accepted at edge N, eligible for grant in cycle N, visible on cdb_ports after edge N+1.
REQ-017 SHALL bound wait: an occupied slot SHALL be granted within ceil(NUM_FU/NUM_CDB) cycles.
REQ-018 SHALL on flush clear all slot occupied bits and all cdb_ports is_valid at the next edge; packets presented during flush SHALL be dropped; rr_ptr SHALL be kept.
REQ-019 SHALL pass dest_tag and result bit-exact; duplicate dest_tags SHALL NOT be checked.

Reset
REQ-020 SHALL on rst low immediately clear all slots, set every cdb_ports field to 0, and set rr_ptr to 0.
REQ-021 SHALL drive fu_wb_rdy all-ones while in reset, since all slots are empty.
REQ-022 SHALL lose in-flight packets on reset mid-operation, with no partial broadcast after deassertion.

Configuration
REQ-023 SHALL support macro CDB_BYPASS_EN: when defined, an incoming valid packet for an empty slot SHALL be arbitration-eligible in the same cycle, giving 1-cycle latency. A slot occupied at the start of the cycle SHALL take priority over a bypass packet from the same FU.
REQ-024 SHALL, when CDB_BYPASS_EN is undefined, behave as REQ-016 with no combinational path from fu_wb_pkt to the grant logic.

Structure
REQ-025 SHALL take writeback_packet_t, PIPE_WIDTH and the tag width from the shared package; the module SHALL define no new typedefs.
REQ-026 SHALL isolate the combinational round-robin multi-grant selector as sub-module cdb_rr_select, with inputs req[NUM_FU] and rr_ptr, and outputs per-port grant index and valid.

Verification
REQ-027 SHALL cover: FU0 sends tag 5 with result 0xDEAD at cycle 0 -> cdb_ports[0] = {1,5,0xDEAD} at cycle 2 and invalid at cycle 3.
REQ-028 SHALL cover: all 4 FUs valid at cycle 0 with rr_ptr=0 -> FU0,FU1 broadcast at cycle 2 and FU2,FU3 at cycle 3; fu_wb_rdy[2:3] low at cycle 1.
REQ-029 SHALL cover: FU3 held continuously valid and FU1 valid -> both broadcast within 2 cycles and rr_ptr wraps from 3 to 0.
REQ-030 SHALL cover: flush asserted at cycle 1 with 3 slots occupied -> no cdb is_valid at cycles 2-3 and rr_ptr unchanged.
REQ-031 SHALL cover: rst pulsed low mid-burst -> cdb_ports zero immediately, fu_wb_rdy=4'hF, rr_ptr=0.
REQ-032 SHALL cover: with CDB_BYPASS_EN defined, FU2 sends tag 9 into an empty arbiter at cycle 0 -> broadcast at cycle 1.
